cordic_rx: RTL and testbench

- Pipelined CORDIC digital downconverter for the receive path, the mirror of the transmit upconverter.
- Multiplies complex samples (I + jQ) by exp(-j·phase) from an internal 32-bit NCO.
- Outputs baseband I/Q to the decimation chain.
- Input is qualified by a valid strobe. The NCO advances once per accepted sample, and output valid tracks the pipeline.

---
 rtl/cordic_rx.sv | 197 +++++++++++++++++++
 tb/tb_cordic_rx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rx.sv
// cordic_rx: pipelined CORDIC downconverter, rotates (I + jQ) by
// exp(-j*phase) from an internal 32-bit NCO that advances per valid sample.
// Optional build macro: CORDIC_RX_DITHER_EN (LFSR dither on phase truncation).
// Ports: clock, reset (sync, active-high), frequency (NCO increment),
//   phase_clear, in_valid, in_data_I/Q (signed samples),
//   out_valid, out_data_I/Q (signed baseband, latency STG or STG+1).
module cordic_rx #(
    parameter int IN_WIDTH   = 16,
    parameter int EXTRA_BITS = 1,
    parameter int OUT_WIDTH  = IN_WIDTH + EXTRA_BITS + 2,
    localparam int WF = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WF-1:0]               frequency,
    input  logic                        phase_clear,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data_I,
    input  logic signed [IN_WIDTH-1:0]  in_data_Q,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data_I,
    output logic signed [OUT_WIDTH-1:0] out_data_Q
);

    localparam int WR  = IN_WIDTH + EXTRA_BITS + 2;
    localparam int WZ  = IN_WIDTH + EXTRA_BITS - 1;
    localparam int STG = IN_WIDTH + EXTRA_BITS - 2;
    localparam int WP  = WF;
    localparam int L   = STG + ((OUT_WIDTH < WR) ? 1 : 0);

    // Arctan of 2^-s, full circle = 2^32, rounded to the Z LSB (2^(WP-WZ-1)).
    function automatic logic [WZ-1:0] ang(input int s);
        logic [31:0] c;
        case (s)
            0:  c = 32'h20000000;
            1:  c = 32'h12E4051E;
            2:  c = 32'h09FB385B;
            3:  c = 32'h051111D4;
            4:  c = 32'h028B0D43;
            5:  c = 32'h0145D7E1;
            6:  c = 32'h00A2F61E;
            7:  c = 32'h00517C55;
            8:  c = 32'h0028BE53;
            9:  c = 32'h00145F2F;
            10: c = 32'h000A2F98;
            11: c = 32'h000517CC;
            12: c = 32'h00028BE6;
            13: c = 32'h000145F3;
            14: c = 32'h0000A2FA;
            15: c = 32'h0000517D;
            default: c = 32'h28BE60DB >> s;
        endcase
        return WZ'((c + (32'd1 << (WP - WZ - 2))) >> (WP - WZ - 1));
    endfunction

    // Arithmetic shift right by s with round-half-up on the last bit out.
    function automatic logic signed [WR-1:0] rsh(
        input logic signed [WR-1:0] v,
        input int s
    );
        logic signed [WR-1:0] t;
        logic signed [WR:0]   e;
        e = {v, 1'b0};
        e = e >>> s;
        t = v >>> s;
        return t + {{(WR-1){1'b0}}, e[0]};
    endfunction

    logic [WP-1:0] phase, ph_use, ph_next, ph_dith;
    logic [L-1:0]  vld;

    logic signed [WR-1:0] x [0:STG-1];
    logic signed [WR-1:0] y [0:STG-1];
    logic signed [WZ-1:0] z [0:STG-2];
    logic signed [WR-1:0] xsh [1:STG-1];
    logic signed [WR-1:0] ysh [1:STG-1];

    logic [1:0]           quad;
    logic signed [WR-1:0] xs, ys, s0, d0, x0, y0;
    logic signed [WZ-1:0] z0;
    logic                 trunc_unused;

    // A cleared phase applies to this cycle's sample and seeds the next one.
    always_comb begin
        ph_use  = phase_clear ? '0 : phase;
        ph_next = in_valid ? ph_use + frequency : ph_use;
    end

`ifdef CORDIC_RX_DITHER_EN
    logic [14:0] lfsr;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= 15'h0001;
        end else if (in_valid) begin
            lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        end
    end

    assign ph_dith = ph_use + WP'(lfsr[WP-WZ-3:0]);
`else
    assign ph_dith = ph_use;
`endif

    assign quad = ph_dith[WP-1:WP-2];
    // Residual within the quadrant minus pi/4: invert the MSB, sign-extend.
    assign z0 = {~ph_dith[WP-3], ~ph_dith[WP-3], ph_dith[WP-4:WP-WZ-1]};
    assign trunc_unused = ^ph_dith[WP-WZ-2:0];

    // Stage 0: rotate by -(quad*pi/2 + pi/4); multiply by (1 - j) gives sqrt2.
    always_comb begin
        xs = WR'(in_data_I) <<< EXTRA_BITS;
        ys = WR'(in_data_Q) <<< EXTRA_BITS;
        s0 = xs + ys;
        d0 = ys - xs;
        x0 = s0;
        y0 = d0;
        unique case (quad)
            2'd0: begin x0 = s0;  y0 = d0;  end
            2'd1: begin x0 = d0;  y0 = -s0; end
            2'd2: begin x0 = -s0; y0 = -d0; end
            2'd3: begin x0 = -d0; y0 = s0;  end
        endcase
    end

    // Stage n shifts by n-1; stage 1 repeats atan(1) for sqrt2 extra gain.
    always_comb begin
        for (int n = 1; n < STG; n++) begin
            xsh[n] = rsh(x[n-1], n - 1);
            ysh[n] = rsh(y[n-1], n - 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= '0;
            vld   <= '0;
            for (int n = 0; n < STG; n++) begin
                x[n] <= '0;
                y[n] <= '0;
            end
            for (int n = 0; n < STG - 1; n++) begin
                z[n] <= '0;
            end
        end else begin
            phase <= ph_next;
            vld   <= {vld[L-2:0], in_valid};
            x[0]  <= x0;
            y[0]  <= y0;
            z[0]  <= z0;
            for (int n = 1; n < STG; n++) begin
                if (z[n-1][WZ-1]) begin
                    x[n] <= x[n-1] - ysh[n];
                    y[n] <= y[n-1] + xsh[n];
                end else begin
                    x[n] <= x[n-1] + ysh[n];
                    y[n] <= y[n-1] - xsh[n];
                end
            end
            for (int n = 1; n < STG - 1; n++) begin
                if (z[n-1][WZ-1]) begin
                    z[n] <= z[n-1] + ang(n - 1);
                end else begin
                    z[n] <= z[n-1] - ang(n - 1);
                end
            end
        end
    end

    assign out_valid = vld[L-1];

    if (OUT_WIDTH == WR) begin : g_direct
        assign out_data_I = x[STG-1];
        assign out_data_Q = y[STG-1];
    end else begin : g_round
        logic signed [OUT_WIDTH-1:0] oi, oq;
        logic                        low_unused;

        assign low_unused = ^{x[STG-1], y[STG-1]};

        always_ff @(posedge clock) begin
            if (reset) begin
                oi <= '0;
                oq <= '0;
            end else begin
                oi <= x[STG-1][WR-1 -: OUT_WIDTH]
                    + OUT_WIDTH'(x[STG-1][WR-OUT_WIDTH-1]);
                oq <= y[STG-1][WR-1 -: OUT_WIDTH]
                    + OUT_WIDTH'(y[STG-1][WR-OUT_WIDTH-1]);
            end
        end

        assign out_data_I = oi;
        assign out_data_Q = oq;
    end

endmodule

// File: tb/tb_cordic_rx.sv
// tb_cordic_rx: self-checking bench for cordic_rx against an ideal
// complex-rotation model with an NCO phase accumulator and valid delay line.
module tb_cordic_rx;

    localparam int  IW  = 16;
    localparam int  OW  = 19;
    localparam int  L   = 15;
    localparam real PI  = 3.14159265358979;
    localparam real G2  = 2.0 * 1.41421356 * 1.6467602;

    logic                 clock;
    logic                 reset;
    logic [31:0]          frequency;
    logic                 phase_clear;
    logic                 in_valid;
    logic signed [IW-1:0] in_data_I;
    logic signed [IW-1:0] in_data_Q;
    logic                 out_valid;
    logic signed [OW-1:0] out_data_I;
    logic signed [OW-1:0] out_data_Q;

    cordic_rx dut (
        .clock       (clock),
        .reset       (reset),
        .frequency   (frequency),
        .phase_clear (phase_clear),
        .in_valid    (in_valid),
        .in_data_I   (in_data_I),
        .in_data_Q   (in_data_Q),
        .out_valid   (out_valid),
        .out_data_I  (out_data_I),
        .out_data_Q  (out_data_Q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        real ei;
        real eq;
        real mag;
    } exp_t;

    typedef struct {
        int i;
        int q;
        int ei;
        int eq;
    } vec_t;

    int          checks;
    int          failures;
    logic [31:0] mph;
    bit          vq[$];
    exp_t        eq_q[$];
    bit          cap_en;
    int          cap_i[$];
    int          cap_q[$];
    int          max_abs;
    vec_t        tbl[8];

    task automatic chk_int(string nm, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chk_real(string nm, int act, real req, real tol);
        real d;
        checks++;
        d = real'(act) - req;
        if (d < 0.0) d = -d;
        if (d > tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0.1f tol=%0.1f",
                     nm, act, req, tol);
        end
    endtask

    function automatic exp_t model(int i, int q, logic [31:0] ph);
        exp_t e;
        real  th, c, s;
        th    = 2.0 * PI * real'(ph) / 4294967296.0;
        c     = $cos(th);
        s     = $sin(th);
        e.ei  = G2 * (real'(i) * c + real'(q) * s);
        e.eq  = G2 * (real'(q) * c - real'(i) * s);
        e.mag = G2 * $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
        return e;
    endfunction

    task automatic drive(bit v, bit pc, int i, int q, logic [31:0] f);
        in_valid    = v;
        phase_clear = pc;
        in_data_I   = 16'(i);
        in_data_Q   = 16'(q);
        frequency   = f;
    endtask

    task automatic step();
        bit          ev;
        logic [31:0] pu;
        exp_t        e;
        real         tol;
        int          ai, aq;
        @(posedge clock);
        ev = 1'b0;
        if (reset) begin
            mph = '0;
            vq.delete();
            repeat (L - 1) vq.push_back(1'b0);
            eq_q.delete();
        end else begin
            pu = phase_clear ? 32'd0 : mph;
            if (in_valid) begin
                eq_q.push_back(model(in_data_I, in_data_Q, pu));
                mph = pu + frequency;
            end else begin
                mph = pu;
            end
            vq.push_back(in_valid);
            ev = vq.pop_front();
        end
        #1;
        chk_int("out_valid", int'(out_valid), int'(ev));
        if (reset) begin
            chk_int("reset_I", int'(out_data_I), 0);
            chk_int("reset_Q", int'(out_data_Q), 0);
        end
        if (ev && out_valid) begin
            checks++;
            if (eq_q.size() == 0) begin
                failures++;
                $display("FAIL no_expected actual=%0d required=1", 0);
            end else begin
                e   = eq_q.pop_front();
                tol = 0.0005 * e.mag + 6.0;
                ai  = int'(out_data_I);
                aq  = int'(out_data_Q);
                chk_real("data_I", ai, e.ei, tol);
                chk_real("data_Q", aq, e.eq, tol);
                if (ai < 0) ai = -ai;
                if (aq < 0) aq = -aq;
                if (ai > max_abs) max_abs = ai;
                if (aq > max_abs) max_abs = aq;
                if (cap_en) begin
                    cap_i.push_back(int'(out_data_I));
                    cap_q.push_back(int'(out_data_Q));
                end
            end
        end
    endtask

    task automatic lat_check(string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 40);
        chk_int(nm, n, L);
    endtask

    task automatic reset_one();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cap_i.delete();
        cap_q.delete();
    endtask

    task automatic chk_cap(string nm, int k, int ei, int eq);
        checks++;
        if (k >= cap_i.size()) begin
            failures++;
            $display("FAIL %s_missing actual=%0d required=%0d",
                     nm, cap_i.size(), k + 1);
        end else begin
            chk_real({nm, "_I"}, cap_i[k], real'(ei), 93.0 + 0.0005 * 152625.0);
            chk_real({nm, "_Q"}, cap_q[k], real'(eq), 93.0 + 0.0005 * 152625.0);
        end
    endtask

    initial begin
        int pI[4];
        int pQ[4];
        checks   = 0;
        failures = 0;
        max_abs  = 0;
        cap_en   = 1'b0;
        mph      = '0;
        pI = '{46578, 0, -46578, 0};
        pQ = '{0, -46578, 0, 46578};
        tbl[0] = '{10000,     0,   46578,       0};
        tbl[1] = '{    0, 10000,       0,   46578};
        tbl[2] = '{-10000,    0,  -46578,       0};
        tbl[3] = '{ 5000,  5000,   23289,   23289};
        tbl[4] = '{-32768,    0, -152625,       0};
        tbl[5] = '{32767, -32768, 152621, -152625};
        tbl[6] = '{-1234,  4321,   -5748,   20126};
        tbl[7] = '{20000, -7000,   93155,  -32604};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) step();

        // frequency 0, constant tone at DC
        reset = 1'b0;
        drive(1, 0, 10000, 0, 32'd0);
        lat_check("s1_latency");
        chk_real("s1_I", int'(out_data_I), 46578.0, 93.0);
        chk_real("s1_Q", int'(out_data_Q), 0.0, 4.0);
        repeat (10) step();

        // quarter-turn steps from phase 0
        reset_one();
        drive(1, 0, 10000, 0, 32'h40000000);
        lat_check("s2_latency");
        for (int k = 0; k < 8; k++) begin
            chk_real("s2_I", int'(out_data_I), real'(pI[k % 4]), 93.0);
            chk_real("s2_Q", int'(out_data_Q), real'(pQ[k % 4]), 93.0);
            step();
        end

        // gaps on in_valid, phase steps only on accepted samples
        reset_one();
        cap_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            drive(k[0] == 1'b0, 0, 10000, 0, 32'h40000000);
            step();
        end
        drive(0, 0, 0, 0, 32'h40000000);
        repeat (L + 2) step();
        for (int k = 0; k < 8; k++) begin
            chk_cap("s3", k, pI[k % 4], pQ[k % 4]);
        end

        // phase_clear on sample 5
        reset_one();
        for (int k = 0; k < 10; k++) begin
            drive(1, k == 5, 10000, 0, 32'h40000000);
            step();
        end
        drive(0, 0, 0, 0, 32'h40000000);
        repeat (L + 2) step();
        chk_cap("s4_clr", 5, 46578, 0);
        chk_cap("s4_next", 6, 0, -46578);

        // one-cycle reset inside a stream
        drive(1, 0, 10000, 0, 32'h40000000);
        repeat (20) step();
        reset = 1'b1;
        step();
        chk_int("s5_valid", int'(out_valid), 0);
        chk_int("s5_I", int'(out_data_I), 0);
        reset = 1'b0;
        lat_check("s5_latency");
        chk_real("s5_first_I", int'(out_data_I), 46578.0, 93.0);
        chk_real("s5_first_Q", int'(out_data_Q), 0.0, 93.0);

        // full-scale corner
        reset_one();
        max_abs = 0;
        for (int k = 0; k < 24; k++) begin
            drive(1, 0, -32768, -32768, 32'h20000000);
            step();
        end
        drive(0, 0, 0, 0, 32'h20000000);
        repeat (L + 2) step();
        chk_cap("s6_first", 0, -152625, -152625);
        chk_int("s6_range", int'(max_abs < 262144), 1);

        // table vectors, all at phase 0 via phase_clear
        reset_one();
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, tbl[k].i, tbl[k].q, 32'h13572468);
            step();
        end
        drive(0, 0, 0, 0, 32'h13572468);
        repeat (L + 2) step();
        for (int k = 0; k < 8; k++) begin
            chk_cap("tbl", k, tbl[k].ei, tbl[k].eq);
        end
        cap_en = 1'b0;

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0,
                  int'($signed(16'($urandom))),
                  int'($signed(16'($urandom))),
                  (k % 500 < 250) ? $urandom : 32'($urandom_range(0, 65535)));
            step();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (L + 4) step();
        chk_int("drain_empty", eq_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
